cdb_rr_arbiter: RTL and testbench
=================================

Name: cdb_rr_arbiter

Overview:
- Parametrised successor to the single-port fixed-priority CDB selector.
- Arbitrates NUM_REQ functional-unit completion requests onto NUM_CDB parallel broadcast channels using round-robin priority, which prevents starvation.
- Broadcast outputs are registered, so results reach RS/ROB/map table one cycle after grant.
- Sits between the FU output stage and every CDB consumer; a flush input squashes in-flight broadcasts.

Parameters:
- NUM_REQ, 8, number of requesting FUs (index 0..NUM_REQ-1).
- NUM_CDB, 2, number of broadcast channels, 1 <= NUM_CDB <= NUM_REQ.
- TAG_W, 5, ROB tag width.
- DATA_W, 32, result value width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  squash: no grants this cycle; broadcasts cleared next cycle.
- req_valid  in  NUM_REQ  per-FU result ready.
- req_tag  in  NUM_REQ*TAG_W  flattened ROB tags, FU i at [i*TAG_W +: TAG_W].
- req_value  in  NUM_REQ*DATA_W  flattened result values, same packing.
- req_ready  out  NUM_REQ  combinational grant; transfer occurs when valid && ready.
- cdb_valid  out  NUM_CDB  registered per-channel broadcast valid.
- cdb_tag  out  NUM_CDB*TAG_W  registered broadcast tags.
- cdb_value  out  NUM_CDB*DATA_W  registered broadcast values.
- rr_ptr_dbg  out  $clog2(NUM_REQ)  current round-robin pointer.

Behaviour:
- Reset (reset==0, async):
  - cdb_valid=0, cdb_tag=0, cdb_value=0, rr_ptr=0.
  - req_ready is 0 while reset is asserted.
  - Reset asserted mid-operation discards any pending grants; outputs clear immediately, without waiting for a clock edge.
- Arbitration (combinational, each cycle):
  - Scan requesters circularly starting at rr_ptr: rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
  - Channel k (k=0..NUM_CDB-1) is assigned the (k+1)-th requester found with req_valid=1.
  - req_ready[i]=1 iff requester i is assigned a channel. At most NUM_CDB bits are set.
  - Channels with no assignment produce no broadcast.
- Handshake: a requester must hold req_valid, tag and value stable until req_ready=1. req_ready never asserts without req_valid.
- Broadcast (registered, latency 1):
  - On the clock edge, cdb_valid[k]<=assigned, with cdb_tag/cdb_value[k] taken from the assigned requester.
  - Unassigned channels get valid=0, tag=0, value=0.
  - A channel holds valid for one cycle only unless it is re-granted.
- Pointer update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - No grants: rr_ptr unchanged.
- Flush:
  - While flush=1, req_ready=0 for all requesters; next edge cdb_valid<=0; rr_ptr unchanged.
  - Flush wins over any simultaneous request.
- Boundaries:
  - All requesters valid: service rotates in contiguous groups of NUM_CDB.
  - NUM_CDB==NUM_REQ: every valid request is granted every cycle.
  - Fewer valid requests than channels: the upper channels are idle.
  - Wrap-around: the scan crosses index NUM_REQ-1 to 0 within the same cycle.

Decomposition:
- sys_defs.svh carries the shared definitions:
  - NUM_CDB and ROB tag width constants.
  - CDB_PACKET extended to an array of NUM_CDB {v, rob_tag, value} entries.
  - EX_CDB_PACKET/CDB_EX_PACKET typedefs adapted to the valid/ready pairs.
- One sub-module, rr_multi_picker: combinational, takes req vector and pointer, returns a per-channel one-hot grant matrix plus last-granted index. It is instantiated once.
- The top level holds the pointer register, the output registers and the flush logic.

Test Plan:
1. Reset: drive all req_valid=1, then pull reset=0 mid-cycle -> cdb_valid, cdb_tag and cdb_value are 0 immediately, req_ready=0, rr_ptr_dbg=0.
2. All 8 FUs valid for 5 cycles from rr_ptr=0 -> grants {0,1}, {2,3}, {4,5}, {6,7}, {0,1}; each broadcast appears one cycle after its grant.
3. Only FU5 valid, tag 0x11, value 0xDEAD -> req_ready=8'b0010_0000 the same cycle; next cycle cdb_valid=2'b01, ch0 tag 0x11, value 0xDEAD; rr_ptr=6.
4. rr_ptr=6 with FUs {1,3,7} valid -> ch0=FU7, ch1=FU1, rr_ptr=2; next cycle FU3 is granted on ch0, rr_ptr=4.
5. flush=1 with FUs {0,2} valid -> req_ready=0 and next-cycle cdb_valid=0, rr_ptr unchanged; after flush=0 -> ch0=FU0, ch1=FU2.
6. NUM_CDB=1 build, no requests for 3 cycles then FU4 valid -> cdb_valid stays 0 and rr_ptr stays 0; then FU4 is granted and rr_ptr=5.

Source files
------------

// File: rtl/cdb_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_rr_arbiter_pkg
// Brief    : Shared CDB definitions: channel/tag constants, multi-channel
//            CDB packet, FU<->CDB valid/ready packets, pointer wrap helper.
// Revision : 1.0 - initial multi-channel round-robin release
// ============================================================================
package cdb_rr_arbiter_pkg;

   localparam int DEF_NUM_REQ = 8;
   localparam int DEF_NUM_CDB = 2;
   localparam int ROB_TAG_W   = 5;
   localparam int CDB_DATA_W  = 32;

   // One broadcast channel entry
   typedef struct packed {
      logic                  v;
      logic [ROB_TAG_W-1:0]  rob_tag;
      logic [CDB_DATA_W-1:0] value;
   } cdb_entry_t;

   // Full broadcast bundle, one entry per channel
   typedef cdb_entry_t [DEF_NUM_CDB-1:0] CDB_PACKET;

   // FU -> arbiter completion request
   typedef struct packed {
      logic                  valid;
      logic [ROB_TAG_W-1:0]  rob_tag;
      logic [CDB_DATA_W-1:0] value;
   } EX_CDB_PACKET;

   // Arbiter -> FU grant
   typedef struct packed {
      logic ready;
   } CDB_EX_PACKET;

   // Circular successor of an index in a ring of n requesters
   function automatic int rr_wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cdb_rr_arbiter_if
// Brief    : FU completion request bus and registered CDB broadcast bus.
//            master = FU/consumer side, slave = arbiter side.
// Revision : 1.0 - initial multi-channel round-robin release
// ============================================================================
interface cdb_rr_arbiter_if
   import cdb_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int NUM_CDB = DEF_NUM_CDB,
   parameter int TAG_W   = ROB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*TAG_W-1:0]  req_tag;
   logic [NUM_REQ*DATA_W-1:0] req_value;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_CDB-1:0]        cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
   logic [NUM_CDB*DATA_W-1:0] cdb_value;

   modport master (
      output req_valid, req_tag, req_value,
      input  req_ready, cdb_valid, cdb_tag, cdb_value
   );

   modport slave (
      input  req_valid, req_tag, req_value,
      output req_ready, cdb_valid, cdb_tag, cdb_value
   );
endinterface
`default_nettype wire

// File: rtl/cdb_rr_arbiter_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_multi_picker
// Brief    : Combinational circular scan from a pointer; channel k receives
//            the (k+1)-th valid requester. Returns a one-hot grant row per
//            channel and the index of the last requester granted.
// Revision : 1.0 - initial multi-channel round-robin release
// ============================================================================
module rr_multi_picker #(
   parameter int NUM_REQ = 8,
   parameter int NUM_CDB = 2
) (
   input  logic [NUM_REQ-1:0]               i_req,
   input  logic [$clog2(NUM_REQ)-1:0]       i_ptr,
   output logic [NUM_CDB-1:0][NUM_REQ-1:0]  o_grant,
   output logic                             o_any_grant,
   output logic [$clog2(NUM_REQ)-1:0]       o_last_idx
);
   localparam int c_PTR_W = $clog2(NUM_REQ);
   localparam int c_CNT_W = $clog2(NUM_CDB + 1);

   logic [c_PTR_W:0]   w_sum;
   logic [c_PTR_W-1:0] w_idx;
   logic [c_CNT_W-1:0] w_cnt;

   // Walk the ring once starting at the pointer, handing out channels in order
   always_comb begin
      o_grant     = '0;
      o_any_grant = 1'b0;
      o_last_idx  = '0;
      w_sum       = '0;
      w_idx       = '0;
      w_cnt       = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         w_sum = {1'b0, i_ptr} + (c_PTR_W+1)'(off);
         if (w_sum >= (c_PTR_W+1)'(NUM_REQ))
            w_sum = w_sum - (c_PTR_W+1)'(NUM_REQ);
         w_idx = w_sum[c_PTR_W-1:0];
         if (i_req[w_idx] && (w_cnt < c_CNT_W'(NUM_CDB))) begin
            for (int k = 0; k < NUM_CDB; k++) begin
               if (w_cnt == c_CNT_W'(k))
                  o_grant[k][w_idx] = 1'b1;
            end
            o_any_grant = 1'b1;
            o_last_idx  = w_idx;
            w_cnt       = w_cnt + c_CNT_W'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_rr_arbiter
// Brief    : Round-robin arbiter of NUM_REQ FU completions onto NUM_CDB
//            registered broadcast channels, with flush squash.
// Revision : 1.0 - initial multi-channel round-robin release
// ============================================================================
module cdb_rr_arbiter
   import cdb_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int NUM_CDB = DEF_NUM_CDB,
   parameter int TAG_W   = ROB_TAG_W,
   parameter int DATA_W  = CDB_DATA_W
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   cdb_rr_arbiter_if.slave              bus,
   output logic [$clog2(NUM_REQ)-1:0]   rr_ptr_dbg
);
   localparam int c_PTR_W = $clog2(NUM_REQ);

   logic [NUM_CDB-1:0][NUM_REQ-1:0] w_grant;
   logic                            w_any_grant;
   logic [c_PTR_W-1:0]              w_last_idx;
   logic                            w_arb_en;
   logic [NUM_REQ-1:0]              w_ready;
   logic [NUM_CDB-1:0]              w_nxt_valid;
   logic [NUM_CDB*TAG_W-1:0]        w_nxt_tag;
   logic [NUM_CDB*DATA_W-1:0]       w_nxt_value;

   logic [NUM_CDB-1:0]              r_cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]        r_cdb_tag;
   logic [NUM_CDB*DATA_W-1:0]       r_cdb_value;
   logic [c_PTR_W-1:0]              r_rr_ptr;

   rr_multi_picker #(
      .NUM_REQ (NUM_REQ),
      .NUM_CDB (NUM_CDB)
   ) u_picker (
      .i_req       (bus.req_valid),
      .i_ptr       (r_rr_ptr),
      .o_grant     (w_grant),
      .o_any_grant (w_any_grant),
      .o_last_idx  (w_last_idx)
   );

   // Grants are suppressed during reset and flush; reset is used raw so
   // req_ready drops the instant reset asserts
   assign w_arb_en = reset & ~flush;

   // Per-requester ready is the OR of its column across all channel rows
   always_comb begin
      w_ready = '0;
      for (int k = 0; k < NUM_CDB; k++)
         w_ready = w_ready | w_grant[k];
      if (!w_arb_en)
         w_ready = '0;
   end

   assign bus.req_ready = w_ready;

   // One-hot mux of the granted requester onto each channel's next payload
   always_comb begin
      w_nxt_valid = '0;
      w_nxt_tag   = '0;
      w_nxt_value = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         w_nxt_valid[k] = w_arb_en & (|w_grant[k]);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_arb_en && w_grant[k][i]) begin
               w_nxt_tag[k*TAG_W +: TAG_W]    = w_nxt_tag[k*TAG_W +: TAG_W]
                                                | bus.req_tag[i*TAG_W +: TAG_W];
               w_nxt_value[k*DATA_W +: DATA_W] = w_nxt_value[k*DATA_W +: DATA_W]
                                                | bus.req_value[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Broadcast registers: every channel reloads each cycle, so a broadcast
   // lasts one cycle unless the channel is granted again
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cdb_valid <= '0;
         r_cdb_tag   <= '0;
         r_cdb_value <= '0;
      end else begin
         r_cdb_valid <= w_nxt_valid;
         r_cdb_tag   <= w_nxt_tag;
         r_cdb_value <= w_nxt_value;
      end
   end

   // Pointer moves just past the last granted requester; holds otherwise
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_rr_ptr <= '0;
      else if (w_arb_en && w_any_grant)
         r_rr_ptr <= c_PTR_W'(rr_wrap_inc(int'(w_last_idx), NUM_REQ));
   end

   assign bus.cdb_valid = r_cdb_valid;
   assign bus.cdb_tag   = r_cdb_tag;
   assign bus.cdb_value = r_cdb_value;
   assign rr_ptr_dbg    = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_rr_arbiter
// Brief    : Directed bench for cdb_rr_arbiter: a 2-channel and a 1-channel
//            instance driven by hand-computed vectors.
// Revision : 1.0 - initial
// ============================================================================
module tb_cdb_rr_arbiter;

   logic       clock;
   logic       reset;
   logic       flush;
   logic [2:0] ptr2;
   logic [2:0] ptr1;

   int vectors     = 0;
   int miscompares = 0;

   cdb_rr_arbiter_if #(.NUM_REQ(8), .NUM_CDB(2), .TAG_W(5), .DATA_W(32)) bus2 ();
   cdb_rr_arbiter_if #(.NUM_REQ(8), .NUM_CDB(1), .TAG_W(5), .DATA_W(32)) bus1 ();

   cdb_rr_arbiter #(.NUM_REQ(8), .NUM_CDB(2), .TAG_W(5), .DATA_W(32)) dut2 (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .bus        (bus2),
      .rr_ptr_dbg (ptr2)
   );

   cdb_rr_arbiter #(.NUM_REQ(8), .NUM_CDB(1), .TAG_W(5), .DATA_W(32)) dut1 (
      .clock      (clock),
      .reset      (reset),
      .flush      (1'b0),
      .bus        (bus1),
      .rr_ptr_dbg (ptr1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [4:0] tag_of(input int i);
      return 5'(8 + i);
   endfunction

   function automatic logic [31:0] val_of(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_defaults();
      for (int i = 0; i < 8; i++) begin
         bus2.req_tag[i*5 +: 5]    = tag_of(i);
         bus2.req_value[i*32 +: 32] = val_of(i);
         bus1.req_tag[i*5 +: 5]    = tag_of(i);
         bus1.req_value[i*32 +: 32] = val_of(i);
      end
   endtask

   initial begin
      logic [7:0] exp_rdy [5];
      exp_rdy = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};

      reset = 1'b0;
      flush = 1'b0;
      bus2.req_valid = '0;
      bus1.req_valid = '0;
      load_defaults();
      tick();
      tick();
      reset = 1'b1;

      // ---- 1: asynchronous reset mid-operation ----
      bus2.req_valid = 8'hFF;
      #1;
      chk("rst_pre_ready", 64'(bus2.req_ready), 64'h03);
      tick();
      chk("rst_pre_valid", 64'(bus2.cdb_valid), 64'h3);
      #3;
      reset = 1'b0;
      #1;
      chk("rst_valid", 64'(bus2.cdb_valid), 64'h0);
      chk("rst_tag",   64'(bus2.cdb_tag),   64'h0);
      chk("rst_value", 64'(bus2.cdb_value), 64'h0);
      chk("rst_ready", 64'(bus2.req_ready), 64'h0);
      chk("rst_ptr",   64'(ptr2),           64'h0);
      chk("rst_ptr1",  64'(ptr1),           64'h0);
      #1;
      reset = 1'b1;
      #1;

      // ---- 2: all requesters valid, groups of two rotate ----
      for (int g = 0; g < 5; g++) begin
         int f;
         f = (2 * g) % 8;
         chk($sformatf("all_ready_%0d", g), 64'(bus2.req_ready), 64'(exp_rdy[g]));
         tick();
         chk($sformatf("all_valid_%0d", g), 64'(bus2.cdb_valid), 64'h3);
         chk($sformatf("all_tag_%0d", g), 64'(bus2.cdb_tag), 64'({tag_of(f + 1), tag_of(f)}));
         chk($sformatf("all_value_%0d", g), 64'(bus2.cdb_value), {val_of(f + 1), val_of(f)});
      end
      chk("all_ptr", 64'(ptr2), 64'd2);

      // ---- 3: single requester FU5 ----
      bus2.req_valid = 8'h20;
      bus2.req_tag[5*5 +: 5]     = 5'h11;
      bus2.req_value[5*32 +: 32] = 32'h0000_DEAD;
      #1;
      chk("fu5_ready", 64'(bus2.req_ready), 64'h20);
      tick();
      chk("fu5_valid", 64'(bus2.cdb_valid), 64'h1);
      chk("fu5_tag",   64'(bus2.cdb_tag),   64'h011);
      chk("fu5_value", bus2.cdb_value,      64'h0000_0000_0000_DEAD);
      chk("fu5_ptr",   64'(ptr2),           64'd6);
      bus2.req_valid = '0;
      load_defaults();

      // ---- 4: wrap-around from pointer 6 with FUs {1,3,7} ----
      bus2.req_valid = 8'h8A;
      #1;
      chk("wrap_ready", 64'(bus2.req_ready), 64'h82);
      tick();
      chk("wrap_valid", 64'(bus2.cdb_valid), 64'h3);
      chk("wrap_tag",   64'(bus2.cdb_tag),   64'({tag_of(1), tag_of(7)}));
      chk("wrap_value", bus2.cdb_value,      {val_of(1), val_of(7)});
      chk("wrap_ptr",   64'(ptr2),           64'd2);
      bus2.req_valid = 8'h08;
      #1;
      chk("wrap3_ready", 64'(bus2.req_ready), 64'h08);
      tick();
      chk("wrap3_valid", 64'(bus2.cdb_valid), 64'h1);
      chk("wrap3_tag",   64'(bus2.cdb_tag),   64'({5'h00, tag_of(3)}));
      chk("wrap3_ptr",   64'(ptr2),           64'd4);
      bus2.req_valid = '0;

      // ---- 5: flush squashes, then requests proceed ----
      flush = 1'b1;
      bus2.req_valid = 8'h05;
      #1;
      chk("flush_ready", 64'(bus2.req_ready), 64'h00);
      tick();
      chk("flush_valid", 64'(bus2.cdb_valid), 64'h0);
      chk("flush_ptr",   64'(ptr2),           64'd4);
      flush = 1'b0;
      #1;
      chk("post_ready", 64'(bus2.req_ready), 64'h05);
      tick();
      chk("post_valid", 64'(bus2.cdb_valid), 64'h3);
      chk("post_tag",   64'(bus2.cdb_tag),   64'({tag_of(2), tag_of(0)}));
      chk("post_ptr",   64'(ptr2),           64'd3);
      bus2.req_valid = '0;
      tick();
      chk("hold_once_valid", 64'(bus2.cdb_valid), 64'h0);

      // ---- 6: single-channel build, idle then FU4 ----
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("c1_idle_valid_%0d", c), 64'(bus1.cdb_valid), 64'h0);
         chk($sformatf("c1_idle_ptr_%0d", c),   64'(ptr1),           64'h0);
      end
      bus1.req_valid = 8'h10;
      #1;
      chk("c1_ready", 64'(bus1.req_ready), 64'h10);
      tick();
      chk("c1_valid", 64'(bus1.cdb_valid), 64'h1);
      chk("c1_tag",   64'(bus1.cdb_tag),   64'(tag_of(4)));
      chk("c1_value", 64'(bus1.cdb_value), 64'(val_of(4)));
      chk("c1_ptr",   64'(ptr1),           64'd5);
      bus1.req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
